// File: rtl/wallace_pkg.sv
// Shared types, default widths and width helpers for the Wallace MAC accumulator.
package wallace_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus a zero-extended PROD_W addend.
module sat_add #(
    parameter int ACC_W  = 16,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] wide_sum;

    // One extra carry bit catches overflow; on overflow clamp to all ones.
    always_comb begin
        wide_sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(addend);
        ovf      = wide_sum[ACC_W];
        sum      = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/wallace_mac_acc.sv
// Dot-product engine: sums COUNT consecutive multiplier products into a
// saturating accumulator and presents each finished sum on a valid/ready port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The input side may drop In_Valid at any time; Out_Valid, once
// raised, stays high with Acc_Out/Ovf stable until Out_Ready is seen or Clear
// flushes the pending result.
module wallace_mac_acc
    import wallace_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int COUNT  = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [PROD_W-1:0] Prod,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              Clear,
    output logic [ACC_W-1:0]  Acc_Out,
    output logic              Ovf,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output state_t            Dbg_State
);

    localparam int              CNT_W = cnt_width(COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             sticky;
    logic             ready_en;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;
    logic             accept;

    sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .acc    (acc),
        .addend (Prod),
        .sum    (acc_sum),
        .ovf    (add_ovf)
    );

    // ready_en keeps In_Ready low while reset is held and until the first edge after release.
    assign In_Ready  = ready_en && (state == ACCUM) && !Clear;
    assign accept    = In_Valid && In_Ready;
    assign Dbg_State = state;

    // Batch FSM: accumulate COUNT products, hold the result until taken; Clear wins over everything.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            ready_en  <= 1'b0;
            Acc_Out   <= '0;
            Ovf       <= 1'b0;
            Out_Valid <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (Clear) begin
                state     <= ACCUM;
                acc       <= '0;
                count     <= '0;
                sticky    <= 1'b0;
                Out_Valid <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (accept) begin
                            if (count == LAST) begin
                                Acc_Out   <= acc_sum;
                                Ovf       <= sticky | add_ovf;
                                Out_Valid <= 1'b1;
                                state     <= HOLD;
                                acc       <= '0;
                                count     <= '0;
                            end else begin
                                acc    <= acc_sum;
                                count  <= count + 1'b1;
                                sticky <= sticky | add_ovf;
                            end
                        end
                    end
                    HOLD: begin
                        if (Out_Valid && Out_Ready) begin
                            Out_Valid <= 1'b0;
                            sticky    <= 1'b0;
                            state     <= ACCUM;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Directed bench for wallace_mac_acc: a 16-bit and a 9-bit accumulator driven
// in lockstep, table-driven batches plus hand-written corner sequences.
module tb_wallace_mac_acc;
    import wallace_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] prod;
    logic       in_valid;
    logic       clear;
    logic       out_ready;

    logic        a_in_ready, a_ovf, a_out_valid;
    logic [15:0] a_acc_out;
    state_t      a_state;
    logic        b_in_ready, b_ovf, b_out_valid;
    logic [8:0]  b_acc_out;
    state_t      b_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0][7:0] prods;
        logic [15:0]     exp_a;
        logic            ovf_a;
        logic [8:0]      exp_b;
        logic            ovf_b;
    } vec_t;

    vec_t vecs[6];

    wallace_mac_acc #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .Prod(prod), .In_Valid(in_valid),
        .In_Ready(a_in_ready), .Clear(clear), .Acc_Out(a_acc_out), .Ovf(a_ovf),
        .Out_Valid(a_out_valid), .Out_Ready(out_ready), .Dbg_State(a_state)
    );

    wallace_mac_acc #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .Prod(prod), .In_Valid(in_valid),
        .In_Ready(b_in_ready), .Clear(clear), .Acc_Out(b_acc_out), .Ovf(b_ovf),
        .Out_Valid(b_out_valid), .Out_Ready(out_ready), .Dbg_State(b_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0][7:0] mk(input logic [7:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives four back-to-back products; returns at the negedge after the 4th accept.
    task automatic feed4(input logic [3:0][7:0] p, input logic ordy);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            prod      = p[i];
            out_ready = ordy;
            #1 check("in_ready_accum", 32'(a_in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{prods: mk(225, 225, 225, 225), exp_a: 16'd900,  ovf_a: 1'b0, exp_b: 9'd511, ovf_b: 1'b1};
        vecs[1] = '{prods: mk(1, 1, 1, 1),         exp_a: 16'd4,    ovf_a: 1'b0, exp_b: 9'd4,   ovf_b: 1'b0};
        vecs[2] = '{prods: mk(255, 255, 255, 255), exp_a: 16'd1020, ovf_a: 1'b0, exp_b: 9'd511, ovf_b: 1'b1};
        vecs[3] = '{prods: mk(0, 0, 0, 0),         exp_a: 16'd0,    ovf_a: 1'b0, exp_b: 9'd0,   ovf_b: 1'b0};
        vecs[4] = '{prods: mk(100, 50, 25, 10),    exp_a: 16'd185,  ovf_a: 1'b0, exp_b: 9'd185, ovf_b: 1'b0};
        vecs[5] = '{prods: mk(200, 200, 200, 0),   exp_a: 16'd600,  ovf_a: 1'b0, exp_b: 9'd511, ovf_b: 1'b1};

        rst_n = 1'b0; prod = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_acc_out", 32'(a_acc_out), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Table-driven batches with the consumer always ready
        foreach (vecs[v]) begin
            feed4(vecs[v].prods, 1'b1);
            check("tbl_out_valid", 32'(a_out_valid), 32'd1);
            check("tbl_acc_a", 32'(a_acc_out), 32'(vecs[v].exp_a));
            check("tbl_ovf_a", 32'(a_ovf), 32'(vecs[v].ovf_a));
            check("tbl_acc_b", 32'(b_acc_out), 32'(vecs[v].exp_b));
            check("tbl_ovf_b", 32'(b_ovf), 32'(vecs[v].ovf_b));
            check("tbl_in_ready_hold", 32'(a_in_ready), 32'd0);
            @(negedge clk);
            check("tbl_out_valid_drop", 32'(a_out_valid), 32'd0);
            check("tbl_in_ready_back", 32'(a_in_ready), 32'd1);
        end

        // Back-pressure: result held for 5 cycles while input is offered and ignored
        feed4(mk(1, 2, 3, 4), 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; prod = 8'd99; out_ready = 1'b0;
            #1;
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_acc_out", 32'(a_acc_out), 32'd10);
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_state", 32'(a_state), 32'(HOLD));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_released", 32'(a_out_valid), 32'd0);
        check("bp_in_ready_back", 32'(a_in_ready), 32'd1);
        feed4(mk(1, 1, 1, 1), 1'b1);
        check("bp_next_valid", 32'(a_out_valid), 32'd1);
        check("bp_next_acc", 32'(a_acc_out), 32'd4);

        // Clear mid-batch with a concurrent product
        @(negedge clk); in_valid = 1'b1; prod = 8'd7;
        @(negedge clk); prod = 8'd8;
        @(negedge clk); clear = 1'b1; prod = 8'd50;
        #1 check("clr_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk); clear = 1'b0; in_valid = 1'b0;
        feed4(mk(1, 1, 1, 1), 1'b1);
        check("clr_out_valid", 32'(a_out_valid), 32'd1);
        check("clr_acc", 32'(a_acc_out), 32'd4);

        // Clear while a result is pending
        feed4(mk(5, 5, 5, 5), 1'b0);
        check("hclr_pending", 32'(a_out_valid), 32'd1);
        check("hclr_acc", 32'(a_acc_out), 32'd20);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("hclr_out_valid", 32'(a_out_valid), 32'd0);
        check("hclr_in_ready", 32'(a_in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hclr_discarded", 32'(a_out_valid), 32'd0);
        feed4(mk(3, 3, 3, 3), 1'b1);
        check("hclr_next_acc", 32'(a_acc_out), 32'd12);

        // Asynchronous reset mid-batch
        @(negedge clk); in_valid = 1'b1; prod = 8'd9;
        @(negedge clk); prod = 8'd9;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(a_in_ready), 32'd0);
        check("arst_out_valid", 32'(a_out_valid), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready_back", 32'(a_in_ready), 32'd1);
        feed4(mk(2, 2, 2, 2), 1'b1);
        check("arst_acc", 32'(a_acc_out), 32'd8);

        // Asynchronous reset while holding a result
        feed4(mk(1, 2, 3, 4), 1'b0);
        check("arsth_pending", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arsth_out_valid", 32'(a_out_valid), 32'd0);
        check("arsth_acc_out", 32'(a_acc_out), 32'd0);
        check("arsth_state", 32'(a_state), 32'(ACCUM));
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arsth_in_ready_back", 32'(a_in_ready), 32'd1);
        feed4(mk(2, 2, 2, 2), 1'b1);
        check("arsth_out_valid2", 32'(a_out_valid), 32'd1);
        check("arsth_acc2", 32'(a_acc_out), 32'd8);
        check("arsth_ovf2", 32'(a_ovf), 32'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
